// File: rtl/lib_axi2local_pkg.sv
// lib_axi2local_pkg: response codes, FSM encodings and range helper for the AXI-to-local bridge
package lib_axi2local_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} r_state_e;
  function automatic logic in_range(input logic [63:0] addr, input logic [63:0] addr_max);
    return addr <= addr_max;
  endfunction
endpackage

// File: rtl/lib_axi_hold_reg.sv
// lib_axi_hold_reg: one-entry valid/ready capture register
module lib_axi_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         clr_i,
  output logic         ready_o,
  output logic         full_o,
  output logic [W-1:0] data_o
);
  logic         full_q;
  logic [W-1:0] data_q;
  assign ready_o = en_i & ~full_q;
  assign full_o  = full_q;
  assign data_o  = data_q;
  // payload survives clr so the local bus stays stable until the next capture
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (valid_i && ready_o) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end
  end
endmodule

// File: rtl/lib_axi2local_ext.sv
// lib_axi2local_ext: AXI4-Lite slave to local register bus bridge with independent read/write FSMs
module lib_axi2local_ext
  import lib_axi2local_pkg::*;
#(
  parameter int              AXI_AW   = 12,
  parameter int              AXI_DW   = 32,
  parameter int unsigned     RD_LAT   = 1,
  parameter longint unsigned ADDR_MAX = (64'd1 << AXI_AW) - 64'd1
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESETN,
  input  logic [AXI_AW-1:0]   S_AXI_AWADDR,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [AXI_DW-1:0]   S_AXI_WDATA,
  input  logic [AXI_DW/8-1:0] S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [AXI_AW-1:0]   S_AXI_ARADDR,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [AXI_DW-1:0]   S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY,
  output logic [AXI_AW-1:0]   ps_to_pl_addr,
  output logic [AXI_DW-1:0]   ps_to_pl_data,
  output logic [AXI_DW/8-1:0] ps_to_pl_strb,
  output logic                ps_to_pl_wen,
  output logic [AXI_AW-1:0]   pl_to_ps_addr,
  output logic                pl_to_ps_ren,
  input  logic [AXI_DW-1:0]   pl_to_ps_data
);
  localparam int SW = AXI_DW / 8;
  logic [1:0]             init_q;
  w_state_e               w_state_q, w_state_d;
  r_state_e               r_state_q, r_state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [AXI_DW-1:0]      rdata_q, rdata_d;
  logic                   aw_full, w_full, ar_full, aw_ok, ar_ok;
  logic                   aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic [AXI_AW-1:0]      aw_addr, ar_addr;
  logic [AXI_DW+SW-1:0]   w_hold;
  lib_axi_hold_reg #(.W(AXI_AW)) u_aw (
    .clk_i(S_AXI_ACLK), .rst_ni(S_AXI_ARESETN), .en_i(init_q[1]), .valid_i(S_AXI_AWVALID),
    .data_i(S_AXI_AWADDR), .clr_i(b_hs), .ready_o(S_AXI_AWREADY), .full_o(aw_full), .data_o(aw_addr)
  );
  lib_axi_hold_reg #(.W(AXI_DW + SW)) u_w (
    .clk_i(S_AXI_ACLK), .rst_ni(S_AXI_ARESETN), .en_i(init_q[1]), .valid_i(S_AXI_WVALID),
    .data_i({S_AXI_WSTRB, S_AXI_WDATA}), .clr_i(b_hs), .ready_o(S_AXI_WREADY), .full_o(w_full), .data_o(w_hold)
  );
  lib_axi_hold_reg #(.W(AXI_AW)) u_ar (
    .clk_i(S_AXI_ACLK), .rst_ni(S_AXI_ARESETN), .en_i(init_q[1] && r_state_q == R_IDLE),
    .valid_i(S_AXI_ARVALID), .data_i(S_AXI_ARADDR), .clr_i(r_hs), .ready_o(S_AXI_ARREADY),
    .full_o(ar_full), .data_o(ar_addr)
  );
  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  assign b_hs  = S_AXI_BVALID & S_AXI_BREADY;
  assign r_hs  = S_AXI_RVALID & S_AXI_RREADY;
  assign aw_ok = in_range(64'(aw_addr), ADDR_MAX);
  assign ar_ok = in_range(64'(ar_addr), ADDR_MAX);
  assign {ps_to_pl_strb, ps_to_pl_data} = w_hold;
  assign ps_to_pl_addr = aw_addr;
  assign pl_to_ps_addr = ar_addr;
  assign S_AXI_RDATA   = rdata_q;
  // strobes are qualified with reset so nothing reaches the local bus in a reset cycle
  always_comb begin
    w_state_d    = w_state_q;
    S_AXI_BVALID = w_state_q == W_RESP;
    S_AXI_BRESP  = (S_AXI_BVALID && !aw_ok) ? RESP_DECERR : RESP_OKAY;
    ps_to_pl_wen = S_AXI_ARESETN && w_state_q == W_ISSUE && aw_ok && |ps_to_pl_strb;
    case (w_state_q)
      W_IDLE:  w_state_d = ((aw_full || aw_hs) && (w_full || w_hs)) ? W_ISSUE : W_IDLE;
      W_ISSUE: w_state_d = W_RESP;
      W_RESP:  w_state_d = S_AXI_BREADY ? W_IDLE : W_RESP;
      default: w_state_d = W_IDLE;
    endcase
  end
  always_comb begin
    r_state_d    = r_state_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    S_AXI_RVALID = r_state_q == R_RESP;
    S_AXI_RRESP  = (S_AXI_RVALID && !ar_ok) ? RESP_DECERR : RESP_OKAY;
    pl_to_ps_ren = S_AXI_ARESETN && r_state_q == R_ISSUE && ar_ok;
    case (r_state_q)
      R_IDLE:  r_state_d = ar_hs ? R_ISSUE : R_IDLE;
      R_ISSUE: begin
        cnt_d     = 4'd1;
        r_state_d = (RD_LAT == 0) ? R_RESP : R_WAIT;
        rdata_d   = (RD_LAT == 0) ? (ar_ok ? pl_to_ps_data : '0) : rdata_q;
      end
      R_WAIT: begin
        cnt_d     = cnt_q + 4'd1;
        r_state_d = (cnt_q == 4'(RD_LAT)) ? R_RESP : R_WAIT;
        rdata_d   = (cnt_q == 4'(RD_LAT)) ? (ar_ok ? pl_to_ps_data : '0) : rdata_q;
      end
      R_RESP:  r_state_d = S_AXI_RREADY ? R_IDLE : R_RESP;
      default: r_state_d = R_IDLE;
    endcase
  end
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      init_q    <= 2'b00;
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      cnt_q     <= 4'd0;
      rdata_q   <= '0;
    end else begin
      init_q    <= {init_q[0], 1'b1};
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
    end
  end
endmodule

// File: tb/tb_lib_axi2local_ext.sv
// tb_lib_axi2local_ext: vector table plus scoreboard checks of the AXI-to-local bridge (RD_LAT=3, ADDR_MAX=0x0FF)
module tb_lib_axi2local_ext;
  logic clk = 1'b0, rstn;
  logic [11:0] awaddr, araddr, ps_addr, pl_addr;
  logic [31:0] wdata, rdata, ps_data, pl_data;
  logic [3:0]  wstrb, ps_strb;
  logic [1:0]  bresp, rresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready, wen, ren;
  int n_chk = 0, n_err = 0, wen_cnt = 0, ren_cnt = 0, both_cnt = 0;
  typedef struct packed { logic [11:0] a; logic [31:0] d; logic [3:0] s; } wexp_t;
  typedef struct { logic wr; logic [11:0] a; logic [31:0] d; logic [3:0] s; int aw_dly; int w_dly; logic [1:0] resp; logic [31:0] rd; } vec_t;
  wexp_t       exp_w[$];
  logic [11:0] exp_ren[$];
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [31:0] lmem [64];
  logic [2:0]  ren_sr = 3'b000;
  vec_t        tbl [14];

  lib_axi2local_ext #(.AXI_AW(12), .AXI_DW(32), .RD_LAT(3), .ADDR_MAX(64'h0FF)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ps_to_pl_addr(ps_addr), .ps_to_pl_data(ps_data), .ps_to_pl_strb(ps_strb), .ps_to_pl_wen(wen),
    .pl_to_ps_addr(pl_addr), .pl_to_ps_ren(ren), .pl_to_ps_data(pl_data)
  );

  always #5 clk = ~clk;

  // local register map: data is only valid exactly RD_LAT clocks after ren
  assign pl_data = ren_sr[2] ? lmem[pl_addr[7:2]] : 32'hBAD0BAD0;
  always @(posedge clk) begin
    ren_sr <= {ren_sr[1:0], ren};
    if (wen)
      for (int b = 0; b < 4; b++)
        if (ps_strb[b]) lmem[ps_addr[7:2]][8*b +: 8] <= ps_data[8*b +: 8];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wen) begin
      wen_cnt++;
      chk("wen_expected", exp_w.size() != 0, 1);
      if (exp_w.size() != 0) chk("wen_payload", {ps_addr, ps_data, ps_strb}, exp_w.pop_front());
    end
    if (ren) begin
      ren_cnt++;
      chk("ren_expected", exp_ren.size() != 0, 1);
      if (exp_ren.size() != 0) chk("ren_addr", pl_addr, exp_ren.pop_front());
    end
    if (wen && ren) both_cnt++;
    if (bvalid && bready) begin
      chk("b_expected", exp_b.size() != 0, 1);
      if (exp_b.size() != 0) chk("bresp", bresp, exp_b.pop_front());
    end
    if (rvalid && rready) begin
      chk("r_expected", exp_r.size() != 0, 1);
      if (exp_r.size() != 0) chk("rresp_rdata", {rresp, rdata}, exp_r.pop_front());
    end
  end

  task automatic send_aw(input logic [11:0] a, input int dly);
    int i;
    repeat (dly) begin @(posedge clk); #1; end
    awaddr = a; awvalid = 1'b1;
    for (i = 0; i < 40; i++) begin @(negedge clk); if (awready) break; end
    chk("aw_handshake", awready, 1);
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int i;
    repeat (dly) begin @(posedge clk); #1; end
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (i = 0; i < 40; i++) begin @(negedge clk); if (wready) break; end
    chk("w_handshake", wready, 1);
    @(posedge clk); #1 wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [11:0] a);
    int i;
    araddr = a; arvalid = 1'b1;
    for (i = 0; i < 40; i++) begin @(negedge clk); if (arready) break; end
    chk("ar_handshake", arready, 1);
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, input int awd, input int wd, input logic [1:0] resp);
    if (a <= 12'h0FF && s != 4'h0) exp_w.push_back('{a, d, s});
    exp_b.push_back(resp);
    fork
      send_aw(a, awd);
      send_w(d, s, wd);
    join
  endtask

  task automatic rd(input logic [11:0] a, input logic [1:0] resp, input logic [31:0] d);
    if (a <= 12'h0FF) exp_ren.push_back(a);
    exp_r.push_back({resp, d});
    send_ar(a);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 80; i++) begin
      if (exp_w.size() + exp_ren.size() + exp_b.size() + exp_r.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_timeout", i < 80, 1);
    @(posedge clk); #1;
  endtask

  task automatic ready_rise(input string name);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk);
    @(negedge clk); chk({name, "_ready_first"}, {awready, wready, arready}, 3'b000);
    @(negedge clk); chk({name, "_ready_second"}, {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c_w, c_r, c_b;
    logic early, stable, wr_low;
    tbl[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 32'h0};
    tbl[1]  = '{1'b0, 12'h010, 32'h0,        4'h0, 0, 0, 2'b00, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 12'h014, 32'h11223344, 4'h5, 0, 2, 2'b00, 32'h0};
    tbl[3]  = '{1'b0, 12'h014, 32'h0,        4'h0, 0, 0, 2'b00, 32'h00220044};
    tbl[4]  = '{1'b1, 12'h0FC, 32'hA5A5A5A5, 4'hF, 2, 0, 2'b00, 32'h0};
    tbl[5]  = '{1'b0, 12'h0FF, 32'h0,        4'h0, 0, 0, 2'b00, 32'hA5A5A5A5};
    tbl[6]  = '{1'b1, 12'h100, 32'h12345678, 4'hF, 0, 0, 2'b11, 32'h0};
    tbl[7]  = '{1'b0, 12'h100, 32'h0,        4'h0, 0, 0, 2'b11, 32'h0};
    tbl[8]  = '{1'b1, 12'h004, 32'hFFFFFFFF, 4'h0, 1, 1, 2'b00, 32'h0};
    tbl[9]  = '{1'b0, 12'h004, 32'h0,        4'h0, 0, 0, 2'b00, 32'h0};
    tbl[10] = '{1'b1, 12'hFFC, 32'h0BADF00D, 4'hF, 0, 3, 2'b11, 32'h0};
    tbl[11] = '{1'b0, 12'h800, 32'h0,        4'h0, 0, 0, 2'b11, 32'h0};
    tbl[12] = '{1'b1, 12'h010, 32'h77000000, 4'h8, 1, 0, 2'b00, 32'h0};
    tbl[13] = '{1'b0, 12'h010, 32'h0,        4'h0, 0, 0, 2'b00, 32'h77ADBEEF};
    for (int i = 0; i < 64; i++) lmem[i] = 32'h0;
    rstn = 1'b0; awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {awready, wready, arready, bvalid, rvalid, wen, ren, bresp, rresp, rdata,
                          ps_addr, ps_data, ps_strb, pl_addr}, '0);
    ready_rise("init");

    // same-cycle AW/W: wen one clock later, BVALID the clock after
    exp_w.push_back('{12'h010, 32'hDEADBEEF, 4'hF}); exp_b.push_back(2'b00);
    awaddr = 12'h010; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk); chk("t1_ready", {awready, wready}, 2'b11);
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk); chk("t1_wen", {wen, bvalid}, 2'b10);
    @(negedge clk); chk("t1_bvalid", {bvalid, bresp, wen}, 4'b1000);
    drain();

    // W first, AW three clocks later
    exp_w.push_back('{12'h020, 32'h12345678, 4'h3}); exp_b.push_back(2'b00);
    wdata = 32'h12345678; wstrb = 4'h3; wvalid = 1'b1;
    @(negedge clk); chk("t2_w_ready", wready, 1);
    @(posedge clk); #1 wvalid = 1'b0;
    wr_low = 1'b1;
    repeat (2) begin @(negedge clk); wr_low &= !wready; end
    @(posedge clk); #1 awaddr = 12'h020; awvalid = 1'b1;
    @(negedge clk); chk("t2_aw_ready", awready, 1); wr_low &= !wready;
    @(posedge clk); #1 awvalid = 1'b0;
    @(negedge clk); chk("t2_wen", wen, 1); wr_low &= !wready;
    @(negedge clk); chk("t2_bvalid", bvalid, 1); wr_low &= !wready;
    @(negedge clk); chk("t2_wready_low", wr_low, 1); chk("t2_wready_back", wready, 1);
    drain();

    foreach (tbl[i]) begin
      c_w = wen_cnt; c_r = ren_cnt;
      if (tbl[i].wr) wr(tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].aw_dly, tbl[i].w_dly, tbl[i].resp);
      else rd(tbl[i].a, tbl[i].resp, tbl[i].rd);
      drain();
      chk("vec_wen_count", wen_cnt - c_w, (tbl[i].wr && tbl[i].a <= 12'h0FF && tbl[i].s != 4'h0) ? 1 : 0);
      chk("vec_ren_count", ren_cnt - c_r, (!tbl[i].wr && tbl[i].a <= 12'h0FF) ? 1 : 0);
    end

    // RD_LAT=3 read with RREADY held low for five clocks
    wr(12'h040, 32'hCAFEF00D, 4'hF, 0, 0, 2'b00);
    drain();
    rready = 1'b0;
    exp_ren.push_back(12'h040); exp_r.push_back({2'b00, 32'hCAFEF00D});
    araddr = 12'h040; arvalid = 1'b1;
    @(negedge clk); chk("t3_arready", arready, 1);
    @(posedge clk); #1 arvalid = 1'b0;
    early = 1'b0;
    repeat (4) begin @(negedge clk); early |= rvalid; end
    chk("t3_rvalid_early", early, 0);
    @(negedge clk); chk("t3_rvalid", {rvalid, rresp, rdata}, {1'b1, 2'b00, 32'hCAFEF00D});
    stable = 1'b1;
    repeat (4) begin @(negedge clk); if (!rvalid || rdata !== 32'hCAFEF00D || arready) stable = 1'b0; end
    chk("t3_rdata_held", stable, 1);
    @(posedge clk); #1 rready = 1'b1;
    drain();

    // simultaneous read and write reach the local bus in the same cycle
    c_b = both_cnt;
    exp_ren.push_back(12'h008); exp_r.push_back({2'b00, 32'h0});
    exp_w.push_back('{12'h00C, 32'h0BADCAFE, 4'hF}); exp_b.push_back(2'b00);
    fork
      send_ar(12'h008);
      send_aw(12'h00C, 0);
      send_w(32'h0BADCAFE, 4'hF, 0);
    join
    drain();
    chk("t5_wen_ren_same_cycle", both_cnt - c_b, 1);

    // reset while write waits in W_RESP and read sits in R_WAIT
    c_w = wen_cnt; c_r = ren_cnt;
    bready = 1'b0;
    exp_w.push_back('{12'h020, 32'h55AA55AA, 4'hF});
    awaddr = 12'h020; wdata = 32'h55AA55AA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    exp_ren.push_back(12'h030); araddr = 12'h030; arvalid = 1'b1;
    @(posedge clk); #1 arvalid = 1'b0;
    @(posedge clk); #1 rstn = 1'b0;
    @(negedge clk); chk("t6_bvalid_held", bvalid, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("t6_after_reset", {bvalid, rvalid, awready, wready, arready, wen, ren}, 7'b0);
    bready = 1'b1;
    ready_rise("t6");
    repeat (6) @(negedge clk);
    chk("t6_wen_count", wen_cnt - c_w, 1);
    chk("t6_ren_count", ren_cnt - c_r, 1);
    chk("t6_queues_empty", exp_w.size() + exp_ren.size() + exp_b.size() + exp_r.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
